ship_placement_ctrl: RTL and testbench
======================================

// Module: ship_placement_ctrl
// PURPOSE
//  Sequences ship placement on the 5x5 board during the game FSM placement state.
//  Owns the cell cursor (1..CELLS, wraps) and the ship orientation.
//  Validates each requested placement (bounds, overlap) and writes accepted ships cell-by-cell to board memory.
//  Tracks the occupancy map and flags done when all ships are placed.
// PARAMETERS
//  COLS       5  board columns
//  ROWS       5  board rows; CELLS=COLS*ROWS must be <=31 (5-bit cell index)
//  NUM_SHIPS  3  ships to place; ship k (0-based) has length k+2 (2,3,4)
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  enable       in   1      0 = freeze all state, cell_we forced 0
//  next_pulse   in   1      1-cycle pulse: cursor +1
//  rot_pulse    in   1      1-cycle pulse: toggle orientation
//  place_pulse  in   1      1-cycle pulse: request placement at cursor
//  cursor       out  5      current cell, 1-based (1..CELLS)
//  horizontal   out  1      1 = horizontal (+1 per cell), 0 = vertical (+COLS per cell)
//  ship_idx     out  2      index of ship being placed (0..NUM_SHIPS)
//  cell_we      out  1      board memory write strobe
//  cell_addr    out  5      board memory address (1-based cell)
//  cell_id      out  2      ship id written (ship_idx+1)
//  occupancy    out  CELLS  bit c-1 set = cell c occupied
//  busy         out  1      1 in CHECK/WRITE
//  reject       out  1      1-cycle pulse: placement refused
//  done         out  1      all ships placed; held until rst
// BEHAVIOUR
//  Reset: state=SELECT, cursor=1, horizontal=1, ship_idx=0, occupancy=0, cell_we=0, cell_addr=0, cell_id=0,
//   busy=0, reject=0, done=0; wr_cnt=0.
//  States: SELECT, CHECK, WRITE, DONE. Any transition requires enable=1; enable=0 holds every register.
//  SELECT: priority place > rot > next (one action per cycle).
//   place -> CHECK (cursor/orientation frozen). rot -> horizontal toggles.
//   next -> cursor+1; cursor==CELLS -> 1 (never 0, never CELLS+1).
//  CHECK (1 cycle): len=ship_idx+2, row=(cursor-1)/COLS, col=(cursor-1)%COLS.
//   Valid iff (horizontal ? col+len<=COLS : row+len<=ROWS) AND no target cell occupied.
//   Valid -> WRITE, wr_cnt=0. Invalid -> SELECT; reject=1 for exactly the next cycle.
//  WRITE: len cycles, one cell each; cell_we=1, cell_addr=cursor+wr_cnt*(horizontal?1:COLS),
//   cell_id=ship_idx+1; occupancy bit set same edge the write is issued; wr_cnt++.
//   After last cell: ship_idx++, cursor=1, horizontal=1; ship_idx==NUM_SHIPS -> DONE, else SELECT.
//  Latency: place_pulse at cycle N -> CHECK at N+1 -> first cell_we at N+2 or reject at N+2.
//  cell_we, cell_addr, cell_id are registered; cell_we=0 outside WRITE (cell_addr/cell_id hold last value).
//  Pulses arriving in CHECK/WRITE/DONE are ignored (not queued).
//  DONE: done=1, all pulses ignored, outputs static.
//  rst mid-WRITE: partial ship discarded, occupancy cleared, full reset values next cycle.
//  No address arithmetic may exceed CELLS: bounds check precedes WRITE.
// TESTING
//  T1 reset: rst 1 cycle -> cursor=1, horizontal=1, ship_idx=0, occupancy=0, done=0, cell_we=0.
//  T2 wrap: 24 next_pulse -> cursor=25; one more -> cursor=1; enable=0 + next -> cursor unchanged.
//  T3 place: horizontal place at cell 1 -> cell_we 2 cycles, addr 1,2, id 1; occupancy=0x3; ship_idx=1.
//  T4 bounds: ship1 (len3) horizontal at cell 4 -> reject 1 cycle, no cell_we, ship_idx stays 1.
//  T5 overlap+priority: rot+next same cycle with cursor 1 -> horizontal=0, cursor stays 1;
//   then vertical at cell 2 (overlaps 2) -> reject.
//  T6 vertical+done: ship1 vertical at cell 3 -> addr 3,8,13; ship2 vertical at 5 -> 5,10,15,20;
//   done=1; further pulses ignored; rst during a WRITE -> occupancy=0.

Source files
------------

// File: rtl/ship_placement_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ship_placement_ctrl
// Purpose  : Sequences ship placement on a COLS x ROWS board. Owns the cell
//            cursor (1..CELLS, wrapping) and the ship orientation, validates
//            each placement request against the board edges and the current
//            occupancy map, and writes accepted ships one cell per cycle to
//            the board memory. Raises done once every ship has been placed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1       clock
//   rst             in   1       synchronous active-high reset
//   i_enable        in   1       0 = freeze all state, write strobe forced low
//   i_next_pulse    in   1       cursor +1 (wraps CELLS -> 1)
//   i_rot_pulse     in   1       toggle orientation
//   i_place_pulse   in   1       request placement of current ship at cursor
//   o_cursor        out  5       current cell, 1-based
//   o_horizontal    out  1       1 = +1 per cell, 0 = +COLS per cell
//   o_ship_idx      out  2       ship being placed (0..NUM_SHIPS)
//   o_cell_we       out  1       board memory write strobe
//   o_cell_addr     out  5       board memory address (1-based cell)
//   o_cell_id       out  2       ship id written (ship_idx+1)
//   o_occupancy     out  CELLS   bit c-1 set = cell c occupied
//   o_busy          out  1       placement being checked / written
//   o_reject        out  1       one-cycle pulse: placement refused
//   o_done          out  1       all ships placed, held until rst
// ============================================================================
module ship_placement_ctrl #(
    parameter int COLS      = 5,
    parameter int ROWS      = 5,
    parameter int NUM_SHIPS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_next_pulse,
    input  logic                   i_rot_pulse,
    input  logic                   i_place_pulse,
    output logic [4:0]             o_cursor,
    output logic                   o_horizontal,
    output logic [1:0]             o_ship_idx,
    output logic                   o_cell_we,
    output logic [4:0]             o_cell_addr,
    output logic [1:0]             o_cell_id,
    output logic [COLS*ROWS-1:0]   o_occupancy,
    output logic                   o_busy,
    output logic                   o_reject,
    output logic                   o_done
);

    localparam int         CELLS   = COLS * ROWS;
    localparam int         MAX_LEN = NUM_SHIPS + 1;
    localparam logic [4:0] c_CELLS = 5'(CELLS);
    localparam logic [4:0] c_COLS  = 5'(COLS);
    localparam logic [4:0] c_ROWS  = 5'(ROWS);
    localparam logic [1:0] c_LAST  = 2'(NUM_SHIPS);

    typedef enum logic [1:0] {
        S_SELECT = 2'd0,
        S_CHECK  = 2'd1,
        S_WRITE  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    logic [4:0]           r_cursor;
    logic                 r_horiz;
    logic [1:0]           r_ship_idx;
    logic [CELLS-1:0]     r_occ;
    logic [2:0]           r_wr_cnt;
    logic                 r_cell_we;
    logic [4:0]           r_cell_addr;
    logic [1:0]           r_cell_id;
    logic                 r_busy;
    logic                 r_reject;
    logic                 r_done;

    // ------------------------------------------------------------------
    // Placement geometry for the current ship at the cursor
    // ------------------------------------------------------------------
    logic [4:0]           w_base;
    logic [4:0]           w_row;
    logic [4:0]           w_col;
    logic [2:0]           w_len;
    logic [4:0]           w_step;
    logic                 w_in_bounds;
    logic [CELLS-1:0]     w_target;
    logic                 w_overlap;
    logic                 w_valid;
    logic [4:0]           w_wr_addr;
    logic [CELLS-1:0]     w_wr_onehot;

    assign w_base = r_cursor - 5'd1;
    assign w_row  = w_base / c_COLS;
    assign w_col  = w_base % c_COLS;
    assign w_len  = {1'b0, r_ship_idx} + 3'd2;
    assign w_step = r_horiz ? 5'd1 : c_COLS;

    // Column overflow in horizontal mode would wrap onto the next row and
    // still land inside the board, so the edge test is done in row/column
    // space rather than on the linear address.
    assign w_in_bounds = r_horiz ? (({1'b0, w_col} + {3'b0, w_len}) <= {1'b0, c_COLS})
                                 : (({1'b0, w_row} + {3'b0, w_len}) <= {1'b0, c_ROWS});

    // Mask of cells the ship would cover; only meaningful when in bounds.
    always_comb begin
        w_target = '0;
        for (int c = 0; c < CELLS; c++) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                if ((k < int'(w_len)) && ((int'(w_base) + k * int'(w_step)) == c)) begin
                    w_target[c] = 1'b1;
                end
            end
        end
    end

    assign w_overlap = |(w_target & r_occ);
    assign w_valid   = w_in_bounds & ~w_overlap;

    // wr_cnt is 0 while in CHECK, so this also yields the first cell there.
    assign w_wr_addr = r_cursor + ({2'b00, r_wr_cnt} * w_step);

    always_comb begin
        w_wr_onehot = '0;
        for (int c = 0; c < CELLS; c++) begin
            w_wr_onehot[c] = (int'(w_wr_addr) == (c + 1));
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SELECT;
            r_cursor    <= 5'd1;
            r_horiz     <= 1'b1;
            r_ship_idx  <= 2'd0;
            r_occ       <= '0;
            r_wr_cnt    <= 3'd0;
            r_cell_we   <= 1'b0;
            r_cell_addr <= 5'd0;
            r_cell_id   <= 2'd0;
            r_busy      <= 1'b0;
            r_reject    <= 1'b0;
            r_done      <= 1'b0;
        end else if (i_enable) begin
            r_reject <= 1'b0;
            case (r_state)
                S_SELECT: begin
                    if (i_place_pulse) begin
                        r_state <= S_CHECK;
                        r_busy  <= 1'b1;
                    end else if (i_rot_pulse) begin
                        r_horiz <= ~r_horiz;
                    end else if (i_next_pulse) begin
                        r_cursor <= (r_cursor == c_CELLS) ? 5'd1 : (r_cursor + 5'd1);
                    end
                end

                S_CHECK: begin
                    if (w_valid) begin
                        // First cell is issued on the same edge that accepts
                        // the placement, giving a two-cycle place-to-write latency.
                        r_state     <= S_WRITE;
                        r_cell_we   <= 1'b1;
                        r_cell_addr <= w_wr_addr;
                        r_cell_id   <= r_ship_idx + 2'd1;
                        r_occ       <= r_occ | w_wr_onehot;
                        r_wr_cnt    <= 3'd1;
                    end else begin
                        r_state  <= S_SELECT;
                        r_busy   <= 1'b0;
                        r_reject <= 1'b1;
                    end
                end

                S_WRITE: begin
                    if (r_wr_cnt == w_len) begin
                        r_cell_we  <= 1'b0;
                        r_wr_cnt   <= 3'd0;
                        r_ship_idx <= r_ship_idx + 2'd1;
                        r_cursor   <= 5'd1;
                        r_horiz    <= 1'b1;
                        r_busy     <= 1'b0;
                        if ((r_ship_idx + 2'd1) == c_LAST) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SELECT;
                        end
                    end else begin
                        r_cell_we   <= 1'b1;
                        r_cell_addr <= w_wr_addr;
                        r_cell_id   <= r_ship_idx + 2'd1;
                        r_occ       <= r_occ | w_wr_onehot;
                        r_wr_cnt    <= r_wr_cnt + 3'd1;
                    end
                end

                S_DONE: begin
                    r_state <= S_DONE;
                end

                default: begin
                    r_state <= S_SELECT;
                end
            endcase
        end
    end

    assign o_cursor     = r_cursor;
    assign o_horizontal = r_horiz;
    assign o_ship_idx   = r_ship_idx;
    // A strobe pending while frozen is presented again once enable returns.
    assign o_cell_we    = r_cell_we & i_enable;
    assign o_cell_addr  = r_cell_addr;
    assign o_cell_id    = r_cell_id;
    assign o_occupancy  = r_occ;
    assign o_busy       = r_busy;
    assign o_reject     = r_reject;
    assign o_done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ship_placement_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ship_placement_ctrl
// Purpose  : Self-checking bench for ship_placement_ctrl. Directed scenarios
//            followed by randomized pulse/enable/reset traffic, all compared
//            cycle by cycle against a transaction-level board model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ship_placement_ctrl;

    localparam int COLS  = 5;
    localparam int ROWS  = 5;
    localparam int CELLS = COLS * ROWS;
    localparam int NSHIP = 3;

    logic               clk;
    logic               tb_rst;
    logic               tb_en;
    logic               tb_nxt;
    logic               tb_rot;
    logic               tb_plc;
    logic [4:0]         o_cursor;
    logic               o_horizontal;
    logic [1:0]         o_ship_idx;
    logic               o_cell_we;
    logic [4:0]         o_cell_addr;
    logic [1:0]         o_cell_id;
    logic [CELLS-1:0]   o_occupancy;
    logic               o_busy;
    logic               o_reject;
    logic               o_done;

    ship_placement_ctrl #(.COLS(COLS), .ROWS(ROWS), .NUM_SHIPS(NSHIP)) u_dut (
        .clk           (clk),
        .rst           (tb_rst),
        .i_enable      (tb_en),
        .i_next_pulse  (tb_nxt),
        .i_rot_pulse   (tb_rot),
        .i_place_pulse (tb_plc),
        .o_cursor      (o_cursor),
        .o_horizontal  (o_horizontal),
        .o_ship_idx    (o_ship_idx),
        .o_cell_we     (o_cell_we),
        .o_cell_addr   (o_cell_addr),
        .o_cell_id     (o_cell_id),
        .o_occupancy   (o_occupancy),
        .o_busy        (o_busy),
        .o_reject      (o_reject),
        .o_done        (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Board model: pending work is a queue of cell addresses still to be
    // written plus flags for a pending reject / pending end-of-ship.
    // ------------------------------------------------------------------
    int  m_cursor, m_horiz, m_ship, m_done;
    int  m_we, m_addr, m_id, m_reject;
    bit  m_pend_rej, m_pend_fin;
    bit  m_occ [1:CELLS];
    int  m_q [$];

    task automatic model_reset();
        m_cursor = 1; m_horiz = 1; m_ship = 0; m_done = 0;
        m_we = 0; m_addr = 0; m_id = 0; m_reject = 0;
        m_pend_rej = 0; m_pend_fin = 0;
        m_q.delete();
        for (int c = 1; c <= CELLS; c++) m_occ[c] = 0;
    endtask

    task automatic model_step(input bit r, input bit e, input bit n, input bit ro, input bit p);
        int len, row, col, a;
        bit ok;
        if (r) begin
            model_reset();
        end else if (e) begin
            m_reject = 0;
            if (m_pend_rej) begin
                m_reject   = 1;
                m_pend_rej = 0;
            end else if (m_q.size() > 0) begin
                a         = m_q.pop_front();
                m_we      = 1;
                m_addr    = a;
                m_id      = m_ship + 1;
                m_occ[a]  = 1;
            end else if (m_pend_fin) begin
                m_we       = 0;
                m_pend_fin = 0;
                m_ship++;
                m_cursor   = 1;
                m_horiz    = 1;
                if (m_ship == NSHIP) m_done = 1;
            end else if (m_done == 0) begin
                if (p) begin
                    len = m_ship + 2;
                    row = (m_cursor - 1) / COLS;
                    col = (m_cursor - 1) % COLS;
                    ok  = m_horiz ? (col + len <= COLS) : (row + len <= ROWS);
                    if (ok) begin
                        for (int k = 0; k < len; k++) begin
                            a = m_cursor + k * (m_horiz ? 1 : COLS);
                            if (m_occ[a]) ok = 0;
                        end
                    end
                    if (ok) begin
                        for (int k = 0; k < len; k++) m_q.push_back(m_cursor + k * (m_horiz ? 1 : COLS));
                        m_pend_fin = 1;
                    end else begin
                        m_pend_rej = 1;
                    end
                end else if (ro) begin
                    m_horiz = 1 - m_horiz;
                end else if (n) begin
                    m_cursor = (m_cursor == CELLS) ? 1 : m_cursor + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        logic [CELLS-1:0] e_occ;
        for (int c = 1; c <= CELLS; c++) e_occ[c-1] = m_occ[c];
        chk("cursor",    32'(o_cursor),     32'(m_cursor));
        chk("horiz",     32'(o_horizontal), 32'(m_horiz));
        chk("ship_idx",  32'(o_ship_idx),   32'(m_ship));
        chk("occupancy", 32'(o_occupancy),  32'(e_occ));
        chk("cell_we",   32'(o_cell_we),    32'(m_we != 0 && tb_en));
        chk("cell_addr", 32'(o_cell_addr),  32'(m_addr));
        chk("cell_id",   32'(o_cell_id),    32'(m_id));
        chk("busy",      32'(o_busy),       32'(m_pend_rej || m_pend_fin));
        chk("reject",    32'(o_reject),     32'(m_reject));
        chk("done",      32'(o_done),       32'(m_done));
    endtask

    int cap_q [$];
    int cap_rej;

    // Drive at the falling edge, step the model on the rising edge,
    // check outputs at the next falling edge.
    task automatic cycle(input bit r, input bit e, input bit n, input bit ro, input bit p);
        tb_rst = r; tb_en = e; tb_nxt = n; tb_rot = ro; tb_plc = p;
        @(posedge clk);
        model_step(r, e, n, ro, p);
        @(negedge clk);
        check_all();
        if (o_cell_we) cap_q.push_back(int'(o_cell_addr));
        if (o_reject)  cap_rej++;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) cycle(0, 1, 0, 0, 0);
    endtask

    initial begin
        tb_rst = 1'b1; tb_en = 1'b1; tb_nxt = 1'b0; tb_rot = 1'b0; tb_plc = 1'b0;
        model_reset();
        @(negedge clk);

        // T1 reset
        cycle(1, 1, 0, 0, 0);
        chk("t1_cursor", 32'(o_cursor), 32'd1);
        chk("t1_occ",    32'(o_occupancy), 32'd0);

        // T2 cursor wrap and enable freeze
        for (int i = 0; i < 24; i++) cycle(0, 1, 1, 0, 0);
        chk("t2_cursor25", 32'(o_cursor), 32'd25);
        cycle(0, 1, 1, 0, 0);
        chk("t2_wrap", 32'(o_cursor), 32'd1);
        cycle(0, 0, 1, 0, 0);
        chk("t2_frozen", 32'(o_cursor), 32'd1);

        // T3 horizontal ship 0 at cell 1
        cap_q.delete(); cap_rej = 0;
        cycle(0, 1, 0, 0, 1);
        idle(4);
        chk("t3_nwr", 32'(cap_q.size()), 32'd2);
        if (cap_q.size() == 2) begin
            chk("t3_a0", 32'(cap_q[0]), 32'd1);
            chk("t3_a1", 32'(cap_q[1]), 32'd2);
        end
        chk("t3_occ",  32'(o_occupancy), 32'h3);
        chk("t3_ship", 32'(o_ship_idx), 32'd1);

        // T4 horizontal len3 at cell 4 runs off the right edge
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
        cap_q.delete(); cap_rej = 0;
        cycle(0, 1, 0, 0, 1);
        idle(3);
        chk("t4_rej",  32'(cap_rej), 32'd1);
        chk("t4_nwr",  32'(cap_q.size()), 32'd0);
        chk("t4_ship", 32'(o_ship_idx), 32'd1);

        // T5 rot beats next; vertical at cell 2 overlaps
        for (int i = 0; i < 22; i++) cycle(0, 1, 1, 0, 0);
        chk("t5_cur1", 32'(o_cursor), 32'd1);
        cycle(0, 1, 1, 1, 0);
        chk("t5_horiz", 32'(o_horizontal), 32'd0);
        chk("t5_cursor", 32'(o_cursor), 32'd1);
        cycle(0, 1, 1, 0, 0);
        cap_q.delete(); cap_rej = 0;
        cycle(0, 1, 0, 0, 1);
        idle(3);
        chk("t5_rej", 32'(cap_rej), 32'd1);
        chk("t5_nwr", 32'(cap_q.size()), 32'd0);

        // T6 vertical ships, done, pulses ignored
        cycle(0, 1, 1, 0, 0);
        cap_q.delete();
        cycle(0, 1, 0, 0, 1);
        idle(5);
        chk("t6_nwr1", 32'(cap_q.size()), 32'd3);
        if (cap_q.size() == 3) begin
            chk("t6_a0", 32'(cap_q[0]), 32'd3);
            chk("t6_a1", 32'(cap_q[1]), 32'd8);
            chk("t6_a2", 32'(cap_q[2]), 32'd13);
        end
        cycle(0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);
        cap_q.delete();
        cycle(0, 1, 0, 0, 1);
        idle(6);
        chk("t6_nwr2", 32'(cap_q.size()), 32'd4);
        if (cap_q.size() == 4) begin
            chk("t6_b0", 32'(cap_q[0]), 32'd5);
            chk("t6_b1", 32'(cap_q[1]), 32'd10);
            chk("t6_b2", 32'(cap_q[2]), 32'd15);
            chk("t6_b3", 32'(cap_q[3]), 32'd20);
        end
        chk("t6_done", 32'(o_done), 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 1);
        chk("t6_cursor", 32'(o_cursor), 32'd1);
        chk("t6_occ",    32'(o_occupancy), 32'h85297);
        chk("t6_done2",  32'(o_done), 32'd1);

        // reset in the middle of a ship write
        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 1);
        idle(2);
        chk("rst_wr_we", 32'(o_cell_we), 32'd1);
        cycle(1, 1, 0, 0, 0);
        chk("rst_wr_occ", 32'(o_occupancy), 32'd0);
        chk("rst_wr_we0", 32'(o_cell_we), 32'd0);

        // randomized games
        for (int g = 0; g < 6; g++) begin
            cycle(1, 1, 0, 0, 0);
            for (int i = 0; i < 700; i++) begin
                cycle($urandom_range(0, 399) == 0,
                      $urandom_range(0, 7) != 0,
                      $urandom_range(0, 1) == 1,
                      $urandom_range(0, 4) == 0,
                      $urandom_range(0, 5) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
